// File: rtl/float_struct.sv
// Shared floating-point types: packed IEEE-754 single, the status code enum and the exponent bias.
package float_struct;

    localparam int BIAS = 127;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float_point_num;

    typedef enum logic [1:0] {
        OK  = 2'd0,
        NAN = 2'd1,
        INF = 2'd2,
        NUL = 2'd3
    } states;

endpackage

// File: rtl/leading_zero_counter.sv
// Combinational 32-bit leading-zero count; count is 32 and zero is set for an all-zero input.
module leading_zero_counter (
    input  logic [31:0] value,
    output logic [5:0]  count,
    output logic        zero
);

    always_comb begin
        count = 6'd32;
        // Ascending scan so the highest set bit is the last to write count.
        for (int i = 0; i < 32; i++) begin
            if (value[i]) count = 6'(31 - i);
        end
        zero = (value == 32'd0);
    end

endmodule

// File: rtl/int_to_float_converter.sv
// Four-stage integer to IEEE-754 single converter with valid/ready handshake and round-to-nearest-even.
module int_to_float_converter
    import float_struct::*;
#(
    parameter bit SIGNED = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [31:0]    arg,
    input  logic           arg_vld,
    output logic           arg_rdy,
    output float_point_num result,
    output states          state,
    output logic           inexact,
    output logic           res_vld,
    input  logic           res_rdy
);

    // Returns {exp, mant, inexact} for a left-aligned magnitude with the leading one dropped.
    function automatic logic [31:0] round_rne(input logic [30:0] norm, input logic [7:0] exp_in);
        logic [22:0] mant;
        logic        guard;
        logic        sticky;
        logic        up;
        logic [23:0] sum;
        logic [7:0]  exp_out;
        mant    = norm[30:8];
        guard   = norm[7];
        sticky  = |norm[6:0];
        up      = guard && (sticky || mant[0]);
        sum     = {1'b0, mant} + {23'd0, up};
        exp_out = sum[23] ? exp_in + 8'd1 : exp_in;
        return {exp_out, sum[22:0], guard | sticky};
    endfunction

    logic        advance;
    logic        vld_p0, vld_p1, vld_p2;
    logic        sign_p0, sign_p1, sign_p2;
    logic [31:0] mag_p0, mag_p1;
    logic [5:0]  lz_p1;
    logic        zero_p1, zero_p2;
    logic [30:0] norm_p2;
    logic [7:0]  exp_p2;
    logic [5:0]  lz_count;
    logic        lz_zero;
    logic [31:0] rnd;
    logic        neg;

    assign advance = !res_vld || res_rdy;
    assign arg_rdy = advance;
    assign neg     = SIGNED && arg[31];
    assign rnd     = round_rne(norm_p2, exp_p2);

    leading_zero_counter u_lzc (
        .value (mag_p0),
        .count (lz_count),
        .zero  (lz_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            res_vld <= 1'b0;
            result  <= '0;
            state   <= OK;
            inexact <= 1'b0;
        end else if (advance) begin
            vld_p0  <= arg_vld;
            vld_p1  <= vld_p0;
            vld_p2  <= vld_p1;
            res_vld <= vld_p2;
            // S4: round and pack
            if (vld_p2) begin
                if (zero_p2) begin
                    result  <= '0;
                    state   <= NUL;
                    inexact <= 1'b0;
                end else begin
                    result  <= '{sign: sign_p2, exp: rnd[31:24], mant: rnd[23:1]};
                    state   <= OK;
                    inexact <= rnd[0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            // S1: sign and absolute value; -2^31 wraps to the unsigned magnitude 2^31
            sign_p0 <= neg;
            mag_p0  <= neg ? (~arg + 32'd1) : arg;
            // S2: leading-zero count
            sign_p1 <= sign_p0;
            mag_p1  <= mag_p0;
            lz_p1   <= lz_count;
            zero_p1 <= lz_zero;
            // S3: normalize; bit 31 of the shifted value is the implicit one and is dropped
            sign_p2 <= sign_p1;
            zero_p2 <= zero_p1;
            norm_p2 <= 31'(mag_p1 << lz_p1);
            exp_p2  <= 8'(BIAS + 31) - {2'b00, lz_p1};
        end
    end

endmodule

// File: doc/int_to_float_converter.md
INT_TO_FLOAT_CONVERTER -- requirements
Module: int_to_float_converter

Interface
REQ-001 SHALL have parameter SIGNED, default 1; 1 means the input is two's complement, 0 means unsigned.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have port arg, input, 32, the integer operand.
REQ-005 SHALL have port arg_vld, input, 1, operand valid.
REQ-006 SHALL have port arg_rdy, output, 1, converter accepts the operand this cycle.
REQ-007 SHALL have port result, output, float_point_num, packed IEEE-754 single (sign, exp[7:0], mant[22:0]).
REQ-008 SHALL have port state, output, 2, a states code: OK or NUL only; NAN and INF are never produced.
REQ-009 SHALL have port inexact, output, 1, set when rounding discarded nonzero bits.
REQ-010 SHALL have port res_vld, output, 1, result/state/inexact valid.
REQ-011 SHALL have port res_rdy, input, 1, consumer accepts the result.

Function
REQ-012 SHALL be a 4-stage pipeline: S1 capture, sign, absolute value; S2 leading-zero count; S3 normalize shift; S4 round and pack.
REQ-013 SHALL have latency exactly 4 cycles from an accepted operand to res_vld when res_rdy is held high, with throughput 1 per cycle.
REQ-014 SHALL accept an operand only when arg_vld && arg_rdy, and SHALL return a result only when res_vld && res_rdy.
REQ-015 SHALL advance the whole pipeline when !res_vld || res_rdy; arg_rdy SHALL equal that advance condition, combinationally.
REQ-016 SHALL hold result, state, inexact and all stage registers stable while res_vld && !res_rdy.
REQ-017 SHALL carry one valid bit per stage; bubbles propagate and never raise res_vld.
REQ-018 SHALL, with SIGNED=1 and arg[31]=1, set sign=1 and magnitude=-arg as 32-bit unsigned; -2147483648 gives magnitude 2^31.
REQ-019 SHALL, with SIGNED=0, set sign=0 and magnitude=arg.
REQ-020 SHALL set exp = 127 + p, where p is the index of the magnitude MSB (0..31).
REQ-021 SHALL left-align the magnitude so the leading one is dropped; mant is the next 23 bits, guard is the following bit, sticky is the OR of all remaining bits.
REQ-022 SHALL round to nearest even: increment when guard && (sticky || mant[0]).
REQ-023 SHALL, on mantissa carry-out from rounding, set mant=0 and exp+1.
REQ-024 SHALL set inexact = guard || sticky.
REQ-025 SHALL, for magnitude 0, output result all zeros, sign 0, state NUL, inexact 0.
REQ-026 SHALL output state OK for every nonzero input.

Reset
REQ-027 SHALL, while rst=0, asynchronously clear all valid bits, res_vld, result, state (OK) and inexact.
REQ-028 SHALL drive arg_rdy=1 while in reset; operands presented during reset are not accepted.
REQ-029 SHALL discard in-flight data on reset mid-operation; no result from before the reset is ever emitted after it.
REQ-030 SHALL first accept an operand on the first rising edge after rst deasserts.

Structure
REQ-031 SHALL take float_point_num and the states enum (OK, NAN, INF, NUL) from the shared float_struct package; the states enum is moved into that package.
REQ-032 SHALL define the bias constant 127 in float_struct.
REQ-033 SHALL implement S2 as sub-module leading_zero_counter, 32-bit combinational, with outputs count[5:0] and zero.

Verification
REQ-034 Bench SHALL cover: 0 -> result 0x00000000, state NUL, inexact 0; 1 -> 0x3F800000 OK; -1 -> 0xBF800000 OK; each res_vld exactly 4 cycles after acceptance.
REQ-035 Bench SHALL cover rounding: 16777217 -> 0x4B800000 inexact 1 (tie, even kept); 16777219 -> 0x4B800002 inexact 1 (tie, round up); 0x7FFFFFFF -> 0x4F000000 inexact 1 (carry-out).
REQ-036 Bench SHALL cover extremes: -2147483648 -> 0xCF000000 inexact 0; with SIGNED=0, 0xFFFFFFFF -> 0x4F800000 inexact 1.
REQ-037 Bench SHALL cover back-pressure: stream 1..8 with res_rdy low for 3 cycles mid-stream -> arg_rdy low while the pipe is full and the output is stalled, outputs stable, all 8 results in order, no loss or duplication.
REQ-038 Bench SHALL cover reset mid-stream: rst low for 1 cycle with 3 operands in flight -> res_vld 0 immediately, none of the 3 emitted, next operand 5 -> 0x40A00000 after 4 cycles.
REQ-039 Bench SHALL cover random regression: 10^5 random 32-bit values with random valid/ready gaps, compared bit-exact against a reference model using round-to-nearest-even.
